// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN     = 64;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch/stall event counters for the fetch stage.
// Only built when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_fetched,
  input  logic        inc_stall,
  output logic [31:0] fetched,
  output logic [31:0] stalled
);

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched <= '0;
      stalled <= '0;
    end else begin
      if (inc_fetched && (fetched != '1)) fetched <= fetched + 32'd1;
      if (inc_stall && (stalled != '1))   stalled <= stalled + 32'd1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory
// and captures the returned word into the IF/ID register. Handles stall,
// redirect-with-flush and halt on HALT_WORD or a bad fetch address.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned MEM_BYTES = 132,
  parameter logic [31:0] HALT_WORD = 32'h00000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] inst_addr_o,
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [31:0]     if_id_inst_o,
  output logic            if_id_valid_o,
  output logic            halted_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_stall_o,
`endif
  output logic            fetch_err_o
);

  localparam logic [XLEN-1:0] LAST_FETCH = XLEN'(MEM_BYTES - 4);

  fetch_state_t    state, next_state;
  logic [XLEN-1:0] pc_q;
  logic            misaligned;
  logic            out_of_range;
  logic            capture;
  logic            flush;
  logic            load_target;
  logic            set_err;

  assign misaligned   = (redirect_target_i[1:0] != 2'b00);
  assign out_of_range = (pc_q > LAST_FETCH);
  assign inst_addr_o  = pc_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= next_state;
  end

  // Next-state: redirect beats the range check, which beats stall and halt-word.
  always_comb begin
    next_state = state;
    unique case (state)
      BOOT: next_state = RUN;
      RUN: begin
        if (redirect_i) begin
          if (misaligned) next_state = HALT;
        end else if (out_of_range) begin
          next_state = HALT;
        end else if (!stall_i && (inst_i == HALT_WORD)) begin
          next_state = HALT;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = BOOT;
    endcase
  end

  // Datapath controls decoded from state and inputs with the same priority.
  always_comb begin
    capture     = 1'b0;
    flush       = 1'b0;
    load_target = 1'b0;
    set_err     = 1'b0;
    halted_o    = (state == HALT);
    if (state == RUN) begin
      if (redirect_i) begin
        flush = 1'b1;
        if (misaligned) set_err = 1'b1;
        else            load_target = 1'b1;
      end else if (out_of_range) begin
        flush   = 1'b1;
        set_err = 1'b1;
      end else if (stall_i) begin
        capture = 1'b0;
      end else if (inst_i == HALT_WORD) begin
        flush = 1'b1;
      end else begin
        capture = 1'b1;
      end
    end
  end

  // PC, IF/ID register and sticky fetch-error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_pc_o    <= '0;
      if_id_inst_o  <= NOP_INST;
      if_id_valid_o <= 1'b0;
      fetch_err_o   <= 1'b0;
    end else begin
      if (load_target)  pc_q <= redirect_target_i;
      else if (capture) pc_q <= pc_q + XLEN'(4);

      if (flush) begin
        if_id_inst_o  <= NOP_INST;
        if_id_valid_o <= 1'b0;
      end else if (capture) begin
        if_id_pc_o    <= pc_q;
        if_id_inst_o  <= inst_i;
        if_id_valid_o <= 1'b1;
      end

      if (set_err) fetch_err_o <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk         (clk),
    .reset       (reset),
    .inc_fetched (capture),
    .inc_stall   ((state == RUN) && stall_i && !redirect_i),
    .fetched     (perf_fetched_o),
    .stalled     (perf_stall_o)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed scoreboard bench for instruction_fetch with a 132-byte memory model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [63:0] redirect_target_i;
  logic [63:0] inst_addr_o;
  logic [31:0] inst_i;
  logic [63:0] if_id_pc_o;
  logic [31:0] if_id_inst_o;
  logic        if_id_valid_o;
  logic        halted_o;
  logic        fetch_err_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_stall_o;
`endif

  logic [31:0] mem [0:32];

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } cap_t;

  cap_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC  (64'h0),
    .MEM_BYTES (132),
    .HALT_WORD (32'h00000000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .inst_addr_o       (inst_addr_o),
    .inst_i            (inst_i),
    .if_id_pc_o        (if_id_pc_o),
    .if_id_inst_o      (if_id_inst_o),
    .if_id_valid_o     (if_id_valid_o),
    .halted_o          (halted_o),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched_o    (perf_fetched_o),
    .perf_stall_o      (perf_stall_o),
`endif
    .fetch_err_o       (fetch_err_o)
  );

  // Combinational instruction memory; out-of-range reads return a marker word.
  always_comb begin
    inst_i = 32'hDEADBEEF;
    if ((inst_addr_o < 64'd132) && (inst_addr_o[1:0] == 2'b00))
      inst_i = mem[int'(inst_addr_o[7:2])];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_capture(input logic [63:0] pc);
    cap_t e;
    e.pc   = pc;
    e.inst = mem[int'(pc >> 2)];
    sb.push_back(e);
  endtask

  // Advance one edge, then sample; any pending scoreboard entry must appear now.
  task automatic step();
    cap_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("cap_valid", 64'(if_id_valid_o), 64'd1);
      chk("cap_pc", if_id_pc_o, e.pc);
      chk("cap_inst", 64'(if_id_inst_o), 64'(e.inst));
    end
  endtask

  task automatic check_reset_values();
    chk("rst_addr", inst_addr_o, 64'h0);
    chk("rst_if_id_pc", if_id_pc_o, 64'h0);
    chk("rst_if_id_inst", 64'(if_id_inst_o), 64'(NOP));
    chk("rst_valid", 64'(if_id_valid_o), 64'd0);
    chk("rst_halted", 64'(halted_o), 64'd0);
    chk("rst_err", 64'(fetch_err_o), 64'd0);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 33; i++) mem[i] = 32'h00A00013 + (32'(i) << 20);
    mem[0] = 32'h01900293;
  endtask

  initial begin
    reset             = 1'b1;
    stall_i           = 1'b0;
    redirect_i        = 1'b0;
    redirect_target_i = 64'h0;
    fill_mem();

    // Phase A: boot, stall, redirect+stall, run off the end of memory.
    step();
    step();
    check_reset_values();
    reset = 1'b0;
    step();
    chk("boot_valid", 64'(if_id_valid_o), 64'd0);
    chk("boot_addr", inst_addr_o, 64'h0);
    expect_capture(64'h0);
    step();
    chk("first_addr", inst_addr_o, 64'h4);
    expect_capture(64'h4);
    step();
    chk("addr_8", inst_addr_o, 64'h8);

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", inst_addr_o, 64'h8);
      chk("stall_pc", if_id_pc_o, 64'h4);
      chk("stall_inst", 64'(if_id_inst_o), 64'(mem[1]));
      chk("stall_valid", 64'(if_id_valid_o), 64'd1);
    end
    stall_i = 1'b0;
    expect_capture(64'h8);
    step();
    chk("resume_addr", inst_addr_o, 64'hC);

    stall_i           = 1'b1;
    redirect_i        = 1'b1;
    redirect_target_i = 64'h40;
    step();
    chk("redir_addr", inst_addr_o, 64'h40);
    chk("redir_valid", 64'(if_id_valid_o), 64'd0);
    chk("redir_inst", 64'(if_id_inst_o), 64'(NOP));
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    expect_capture(64'h40);
    step();
    chk("after_redir_addr", inst_addr_o, 64'h44);

    redirect_i        = 1'b1;
    redirect_target_i = 64'h7C;
    step();
    redirect_i = 1'b0;
    chk("redir7c_addr", inst_addr_o, 64'h7C);
    expect_capture(64'h7C);
    step();
    expect_capture(64'h80);
    step();
    chk("end_addr", inst_addr_o, 64'h84);
    chk("end_halted_pre", 64'(halted_o), 64'd0);
    step();
    chk("range_halted", 64'(halted_o), 64'd1);
    chk("range_err", 64'(fetch_err_o), 64'd1);
    chk("range_valid", 64'(if_id_valid_o), 64'd0);
    chk("range_addr", inst_addr_o, 64'h84);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", 64'(perf_fetched_o), 64'd6);
    chk("perf_stall", 64'(perf_stall_o), 64'd3);
`endif
    redirect_i        = 1'b1;
    redirect_target_i = 64'h0;
    step();
    redirect_i = 1'b0;
    chk("halt_ignore_addr", inst_addr_o, 64'h84);
    chk("halt_ignore_halted", 64'(halted_o), 64'd1);

    // Reset while halted restores every reset value.
    reset = 1'b1;
    step();
    check_reset_values();

    // Phase B: halt word at address 12.
    mem[3] = 32'h00000000;
    reset  = 1'b0;
    step();
    expect_capture(64'h0);
    step();
    expect_capture(64'h4);
    step();
    expect_capture(64'h8);
    step();
    chk("hw_addr_pre", inst_addr_o, 64'hC);
    step();
    chk("hw_valid", 64'(if_id_valid_o), 64'd0);
    chk("hw_inst", 64'(if_id_inst_o), 64'(NOP));
    chk("hw_halted", 64'(halted_o), 64'd1);
    chk("hw_err", 64'(fetch_err_o), 64'd0);
    chk("hw_addr", inst_addr_o, 64'hC);
    redirect_i        = 1'b1;
    redirect_target_i = 64'h20;
    step();
    redirect_i = 1'b0;
    chk("hw_redir_addr", inst_addr_o, 64'hC);
    chk("hw_redir_halted", 64'(halted_o), 64'd1);

    // Phase C: misaligned redirect target.
    reset = 1'b1;
    step();
    check_reset_values();
    fill_mem();
    reset = 1'b0;
    step();
    expect_capture(64'h0);
    step();
    redirect_i        = 1'b1;
    redirect_target_i = 64'h42;
    step();
    redirect_i = 1'b0;
    chk("mis_halted", 64'(halted_o), 64'd1);
    chk("mis_err", 64'(fetch_err_o), 64'd1);
    chk("mis_valid", 64'(if_id_valid_o), 64'd0);
    chk("mis_addr", inst_addr_o, 64'h4);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
